// File: rtl/cpu0_oci_pkg.sv
// Shared types and default widths for the cpu0 OCI DCT trace capture path.
package cpu0_oci_pkg;

    // Default width of one packed DCT trace word.
    localparam int DCT_WIDTH_DEFAULT   = 30;
    // Default width of the valid-entry count carried with each word.
    localparam int COUNT_WIDTH_DEFAULT = 4;

    // Capture state encoding. ST_SPARE is never entered on purpose and
    // falls through to ST_DONE if it is ever seen.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_SPARE = 2'd3
    } state_t;

endpackage

// File: rtl/cpu0_oci_sync_fifo.sv
// Single-clock FIFO with a registered head word, fill count and synchronous clear.
// The head register is preloaded with whatever word will be oldest after the
// current edge, so a push into an empty FIFO is visible on the next cycle and
// a pop exposes the following word with no bubble.
module cpu0_oci_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [FW-1:0]    fill_level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [FW-1:0]    fill_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    // A clear swallows any push or pop issued in the same cycle.
    assign do_push = push && !clear;
    assign do_pop  = pop && out_valid && !clear;

    // Next read pointer, next fill count and the word that will be oldest after this edge.
    always_comb begin
        rd_ptr_next = rd_ptr;
        fill_next   = fill_level;
        head_next   = mem[rd_ptr];
        if (do_pop) begin
            rd_ptr_next = rd_ptr + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   fill_next = fill_level + FW'(1);
            2'b01:   fill_next = fill_level - FW'(1);
            default: fill_next = fill_level;
        endcase
        // The new head may be the word being written this very edge.
        if (do_push && (wr_ptr == rd_ptr_next)) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage array; written only on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, fill count and the registered head word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            fill_level <= fill_next;
            out_valid  <= (fill_next != '0);
            if (fill_next != '0) begin
                out_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/cpu0_oci_dct_capture.sv
// Capture and drain block for the cpu0 OCI DCT trace stream: qualifies pushes
// from the trace packer, buffers them, presents them on a drain port and
// follows graceful-end / abort signalling with drop and word statistics.
//
// Drain handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and
// out_data/out_count hold steady while out_valid is high and out_ready is low.
module cpu0_oci_dct_capture
    import cpu0_oci_pkg::*;
#(
    parameter int DCT_WIDTH   = DCT_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
    parameter int DEPTH       = 16,
    parameter int DROP_WIDTH  = 8,
    localparam int FW = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dct_valid,
    input  logic [DCT_WIDTH-1:0]   dct_buffer,
    input  logic [COUNT_WIDTH-1:0] dct_count,
    input  logic                   test_ending,
    input  logic                   test_has_ended,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DCT_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic [FW-1:0]          fill_level,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count,
    output logic [31:0]            word_count,
    output logic [1:0]             state,
    output logic                   done
);

    localparam int W = DCT_WIDTH + COUNT_WIDTH;

    state_t         state_q;
    logic           push_req;
    logic           pop;
    logic           full;
    logic           push_ok;
    logic           push_drop;
    logic [W-1:0]   fifo_out;

    assign state = state_q;

    // Only RUN accepts trace words; an abort discards the push outright, so it
    // is neither stored nor counted as a drop.
    assign push_req  = dct_valid && (dct_count != '0) && (state_q == ST_RUN) && !test_has_ended;
    assign pop       = out_valid && out_ready;
    assign full      = (fill_level == FW'(DEPTH));
    // A full FIFO still takes a word when the sink frees a slot on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    cpu0_oci_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_ok),
        .push_data  ({dct_count, dct_buffer}),
        .pop        (pop),
        .clear      (test_has_ended),
        .out_valid  (out_valid),
        .out_data   (fifo_out),
        .fill_level (fill_level)
    );

    assign out_count = fifo_out[W-1 -: COUNT_WIDTH];
    assign out_data  = fifo_out[DCT_WIDTH-1:0];

    // Capture state machine; done is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            done    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (test_has_ended) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end else if (test_ending) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No pushes arrive in DRAIN, so an empty FIFO means nothing is in flight.
                    if (test_has_ended || (fill_level == '0)) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                    done    <= 1'b1;
                end
                default: begin
                    state_q <= ST_DONE;
                    done    <= 1'b1;
                end
            endcase
        end
    end

    // Accepted-word counter (wrapping) and drop statistics (saturating, sticky flag).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                word_count <= word_count + 32'd1;
            end
            if (push_drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu0_oci_dct_capture.sv
// Bench for cpu0_oci_dct_capture: directed scenarios with a drain-side scoreboard.
module tb_cpu0_oci_dct_capture;

    logic        clk;
    logic        reset_n;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [31:0] word_count;
    logic [1:0]  state;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    cpu0_oci_dct_capture #(
        .DCT_WIDTH   (30),
        .COUNT_WIDTH (4),
        .DEPTH       (16),
        .DROP_WIDTH  (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .word_count     (word_count),
        .state          (state),
        .done           (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a word leaves on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        logic [33:0] exp;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected got=%h/%h want=<none>", out_count, out_data);
            end else begin
                exp = exp_q.pop_front();
                if ({out_count, out_data} !== exp) begin
                    errors++;
                    $display("FAIL drain_word got=%h/%h want=%h/%h", out_count, out_data, exp[33:30], exp[29:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset_n        = 1'b0;
        dct_valid      = 1'b0;
        dct_buffer     = '0;
        dct_count      = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete();
    endtask

    // Drive one cycle of input; push the expected word when it should be stored.
    task automatic drive(input logic v, input logic [29:0] d, input logic [3:0] c, input bit accept);
        dct_valid  = v;
        dct_buffer = d;
        dct_count  = c;
        if (accept) exp_q.push_back({c, d});
        @(posedge clk);
        #1;
        dct_valid      = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_data, out_count, fill_level, overflow, drop_count, word_count, state, done} !== '0) begin
            errors++;
            $display("FAIL reset_values got v=%b d=%h c=%h f=%0d o=%b dr=%0d w=%0d s=%0d dn=%b want all zero",
                     out_valid, out_data, out_count, fill_level, overflow, drop_count, word_count, state, done);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 30'(i), 4'd3, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 30'(i) || out_count !== 4'd3) begin
                errors++;
                $display("FAIL basic_latency got v=%b d=%h c=%h want v=1 d=%h c=3", out_valid, out_data, out_count, 30'(i));
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (fill_level !== 5'd0 || word_count !== 32'd5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got f=%0d w=%0d v=%b want f=0 w=5 v=0", fill_level, word_count, out_valid);
        end
    endtask

    task automatic test_zero_count();
        drive(1'b1, 30'h3FF, 4'd0, 1'b0);
        checks++;
        if (word_count !== 32'd5 || overflow !== 1'b0 || fill_level !== 5'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL zero_count got w=%0d o=%b f=%0d dr=%0d want w=5 o=0 f=0 dr=0", word_count, overflow, fill_level, drop_count);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 30'h100 + 30'(i), 4'((i % 15) + 1), i < 16);
        end
        checks++;
        if (fill_level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd4 || word_count !== 32'd21) begin
            errors++;
            $display("FAIL overflow got f=%0d o=%b dr=%0d w=%0d want f=16 o=1 dr=4 w=21", fill_level, overflow, drop_count, word_count);
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b1;
        drive(1'b1, 30'h200, 4'd9, 1'b1);
        checks++;
        if (fill_level !== 5'd16 || drop_count !== 8'd4 || word_count !== 32'd22) begin
            errors++;
            $display("FAIL full_push_pop got f=%0d dr=%0d w=%0d want f=16 dr=4 w=22", fill_level, drop_count, word_count);
        end
        for (int i = 0; i < 17; i++) drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (fill_level !== 5'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain got f=%0d left=%0d want f=0 left=0", fill_level, exp_q.size());
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 30'h300 + 30'(i), 4'd5, 1'b1);
        test_ending = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (state !== 2'd1 || fill_level !== 5'd3) begin
            errors++;
            $display("FAIL drain_enter got s=%0d f=%0d want s=1 f=3", state, fill_level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && done !== 1'b1; k++) drive(1'b1, 30'h3AA, 4'd7, 1'b0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout got done=%b want 1", done);
        end
        checks++;
        if (state !== 2'd2 || word_count !== 32'd3 || drop_count !== 8'd0 || fill_level !== 5'd0 ||
            out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_done got s=%0d w=%0d dr=%0d f=%0d v=%b left=%0d want s=2 w=3 dr=0 f=0 v=0 left=0",
                     state, word_count, drop_count, fill_level, out_valid, exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 30'h400 + 30'(i), 4'd2, 1'b1);
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
        drive(1'b1, 30'h4FF, 4'd2, 1'b0);
        exp_q.delete();
        checks++;
        if (state !== 2'd2 || done !== 1'b1 || fill_level !== 5'd0 || out_valid !== 1'b0 ||
            word_count !== 32'd8 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort got s=%0d dn=%b f=%0d v=%b w=%0d dr=%0d o=%b want s=2 dn=1 f=0 v=0 w=8 dr=0 o=0",
                     state, done, fill_level, out_valid, word_count, drop_count, overflow);
        end
        out_ready = 1'b1;
        drive(1'b1, 30'h4EE, 4'd1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || word_count !== 32'd8 || state !== 2'd2) begin
            errors++;
            $display("FAIL abort_hold got v=%b w=%0d s=%0d want v=0 w=8 s=2", out_valid, word_count, state);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 30'h500 + 30'(i), 4'd6, 1'b1);
        out_ready   = 1'b1;
        test_ending = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (state !== 2'd1 || fill_level !== 5'd3) begin
            errors++;
            $display("FAIL mid_drain got s=%0d f=%0d want s=1 f=3", state, fill_level);
        end
        #1 reset_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({out_valid, out_data, out_count, fill_level, overflow, drop_count, word_count, state, done} !== '0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%h c=%h f=%0d o=%b dr=%0d w=%0d s=%0d dn=%b want all zero",
                     out_valid, out_data, out_count, fill_level, overflow, drop_count, word_count, state, done);
        end
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_full_push_pop();
        test_drain();
        test_abort();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_words got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu0_oci_dct_capture.md
# cpu0_oci_dct_capture

Parametrised capture and drain block for the cpu0 OCI data-compression-trace (DCT) stream. Accepts packed DCT words with their valid-entry count from the trace packer, buffers them in a FIFO, and presents them on a ready/valid drain port for the simulation test bench or an off-chip trace sink. It tracks test-end signalling: on a graceful end it drains cleanly, and on an abort it flushes and stops. It also keeps overflow and word statistics.

## Interface
- DCT_WIDTH, 30: width of one packed DCT word.
- COUNT_WIDTH, 4: width of the valid-entry count carried with each word.
- DEPTH, 16: FIFO depth in words; power of two, minimum 2.
- DROP_WIDTH, 8: width of the saturating drop counter.
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- dct_valid  in  1  dct_buffer/dct_count are valid this cycle.
- dct_buffer  in  DCT_WIDTH  packed trace word.
- dct_count  in  COUNT_WIDTH  number of valid entries in dct_buffer; 0 means nothing to store.
- test_ending  in  1  graceful end request; level or pulse.
- test_has_ended  in  1  abort; level or pulse.
- out_valid  out  1  out_data/out_count hold a word.
- out_ready  in  1  sink accepts the word when high together with out_valid.
- out_data  out  DCT_WIDTH  oldest buffered word.
- out_count  out  COUNT_WIDTH  count stored with out_data.
- fill_level  out  $clog2(DEPTH)+1  words currently buffered.
- overflow  out  1  sticky; set on any dropped push.
- drop_count  out  DROP_WIDTH  dropped pushes, saturating at all-ones.
- word_count  out  32  accepted pushes, wraps modulo 2^32.
- state  out  2  current state encoding.
- done  out  1  high in DONE.

## Operation
- States: RUN (2'd0), DRAIN (2'd1), DONE (2'd2). 2'd3 is unused and recovers to DONE.
- Push request = dct_valid && dct_count != 0 && state == RUN. Requests in DRAIN or DONE are ignored and are not counted as drops.
- Pop = out_valid && out_ready.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - An accepted push stores {dct_count, dct_buffer} and increments word_count.
  - A rejected push sets overflow and increments drop_count, which saturates.
- RUN -> DRAIN when test_ending=1. The push request in that same cycle is still accepted.
- DRAIN -> DONE when fill_level == 0 and there is no push or pop in flight.
- Any state -> DONE when test_has_ended=1.
  - The FIFO is cleared on the next edge; out_valid falls and fill_level becomes 0.
  - A push in that cycle is discarded and not counted.
  - test_has_ended takes priority over test_ending.
- DONE is terminal until reset. out_valid stays 0 and the counters freeze.
- In DONE, overflow, drop_count and word_count stay readable.

## Timing
- Reset values: out_valid=0, out_data=0, out_count=0, fill_level=0, overflow=0, drop_count=0, word_count=0, state=RUN, done=0.
- Reset asserted mid-operation clears everything immediately (asynchronous); buffered words are lost.
- FIFO output is registered. A push into an empty FIFO at edge N gives out_valid=1 from after edge N, i.e. first visible in cycle N+1.
- No combinational path from dct_valid to out_valid, or from out_ready to any input-side signal.
- out_data and out_count stay stable while out_valid && !out_ready.
- Sustained throughput is 1 word/cycle with simultaneous push and pop. fill_level is unchanged in that case.
- fill_level, overflow, drop_count and word_count update on the same edge as the event that causes them.
- done rises on the edge where state enters DONE.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from fill_level.

## Structure
- Package cpu0_oci_pkg holds:
  - state encoding localparams (ST_RUN, ST_DRAIN, ST_DONE);
  - default widths: DCT_WIDTH=30, COUNT_WIDTH=4.
- Sub-module cpu0_oci_sync_fifo:
  - width DCT_WIDTH+COUNT_WIDTH, depth DEPTH;
  - push/pop/clear, registered output, fill count.
- The top level holds the state machine, push qualification, and the drop and word counters.

## Test plan
- Five pushes of 30'h0000_0001..5, count 4'd3, with out_ready=1 -> five words out in order, each one cycle after its push; word_count=5, fill_level ends 0.
- DEPTH=16, out_ready=0, 20 pushes -> fill_level=16, overflow=1, drop_count=4; draining then yields the first 16 words in order.
- Full FIFO, out_ready=1 and a push in the same cycle -> push accepted, fill_level stays 16, drop_count unchanged.
- Push with dct_count=0 -> ignored, word_count unchanged, no overflow.
- 3 words buffered, test_ending pulse, out_ready=1 -> state=DRAIN, later pushes ignored, 3 words delivered, then state=DONE and done=1.
- 8 words buffered, test_has_ended in the same cycle as test_ending and a push -> next cycle state=DONE, fill_level=0, out_valid=0, word_count=8; reset_n low mid-drain -> all outputs at reset values immediately.
